// File: rtl/div_ratio_pkg.sv
// div_ratio_pkg: shared types, constants and power-of-two helper for the divider ratio detector
package div_ratio_pkg;
    localparam int LOG2_W = 5;

    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    // Returns {isPow2, log2}; log2 is the index of the single set bit, zero otherwise.
    function automatic logic [LOG2_W:0] pow2Info(input logic [31:0] value);
        logic [LOG2_W-1:0] idx;
        int ones;
        idx = '0;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                ones++;
                idx = i[LOG2_W-1:0];
            end
        end
        return (ones == 1) ? {1'b1, idx} : '0;
    endfunction
endpackage

// File: rtl/div_ratio_detector_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser followed by a registered rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sigIn,
    output logic rise
);
    logic [2:0] syncQ;

    // syncQ[0..1] synchronise, syncQ[2] holds the previous synchronised level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncQ <= '0;
            rise  <= 1'b0;
        end else begin
            syncQ <= {syncQ[1:0], sigIn};
            rise  <= syncQ[1] & ~syncQ[2];
        end
    end
endmodule

// File: rtl/div_ratio_detector.sv
// div_ratio_detector: measures the period of a divided clock in clk cycles, with lock and timeout
module div_ratio_detector
    import div_ratio_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    output logic              is_pow2,
    output logic [LOG2_W-1:0] log2_n,
    output logic              locked,
    output logic              timeout
);
    localparam int              MW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);

    state_t            state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [MW-1:0]     matchCnt, nextMatch;
    logic [LOG2_W:0]   info;
    logic              rise;

    sync_edge_detect uSync (
        .clk   (clk),
        .rst   (rst),
        .sigIn (sig_in),
        .rise  (rise)
    );

    assign info = pow2Info(32'(cnt));

    // Next state and the match count a rise would produce; a rise always wins over timeout
    always_comb begin
        nextState = state;
        nextMatch = MW'(1);
        if (rise) nextState = MEASURE;
        else if (state != STALL && cnt == TO_VAL) nextState = STALL;
        if (cnt == period) nextMatch = (matchCnt == LOCK_VAL) ? matchCnt : matchCnt + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nextState;
    end

    // Period counter, reported period, lock and timeout flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            matchCnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            is_pow2      <= 1'b0;
            log2_n       <= '0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (rise) begin
                cnt     <= CNT_W'(1);
                timeout <= 1'b0;
                if (state == MEASURE) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                    is_pow2      <= info[LOG2_W];
                    log2_n       <= info[LOG2_W-1:0];
                    matchCnt     <= nextMatch;
                    locked       <= nextMatch >= LOCK_VAL;
                end
            end else begin
                if (cnt != '1) cnt <= cnt + 1'b1;
                if (nextState == STALL && state != STALL) begin
                    timeout  <= 1'b1;
                    locked   <= 1'b0;
                    matchCnt <= '0;
                end
            end
        end
    end
endmodule
